// File: rtl/core_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface core_fetch_if;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;

  modport master (
    output IMEM_REQ,
    output IMEM_ADDR,
    input  IMEM_GNT,
    input  IMEM_RVALID,
    input  IMEM_RDATA
  );

  modport slave (
    input  IMEM_REQ,
    input  IMEM_ADDR,
    output IMEM_GNT,
    output IMEM_RVALID,
    output IMEM_RDATA
  );
endinterface

// File: rtl/core_fetch.sv
// Instruction fetch stage: keeps the fetch PC, issues in-order imem reads
// (at most two in flight or buffered), and presents instructions to decode
// from a 2-entry {pc, word} buffer. REDIRECT flushes and restarts fetch.
// Optional build macro CORE_FETCH_MISALIGN_EN: a misaligned redirect target
// parks the stage in HALT with MISALIGN=1 until an aligned redirect.
// IMEM_REQ and the INST* outputs are combinational views of the state flops
// (REQ must drop in the redirect cycle and react to this cycle's STALL).
module core_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         STALL,
  input  logic         REDIRECT,
  input  logic [31:0]  REDIRECT_PC,
  core_fetch_if.master imem,
  output logic [31:0]  INST,
  output logic [31:0]  INST_PC,
  output logic         INST_VALID,
  output logic         MISALIGN
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned SUM_W = 3;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } entry_t;

  state_e           state_q, state_d;
  logic             misalign_q, misalign_d;
  logic             started_q, started_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  entry_t           fb_q [2];
  entry_t           fb_d [2];
  logic [CNT_W-1:0] fb_cnt_q, fb_cnt_d;
  logic [XLEN-1:0]  out_pc_q [2];
  logic [XLEN-1:0]  out_pc_d [2];
  logic [1:0]       out_disc_q, out_disc_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic [XLEN-1:0]  redirect_pc_c;
  logic             misalign_hit_c;
  logic             valid_c;
  logic             consume_c;
  logic             rsp_c;
  logic             write_c;
  logic [SUM_W-1:0] load_c;
  logic             req_c;
  logic             grant_c;

`ifdef CORE_FETCH_MISALIGN_EN
  assign redirect_pc_c  = REDIRECT_PC;
  assign misalign_hit_c = (REDIRECT_PC[1:0] != 2'b00);
`else
  assign redirect_pc_c  = REDIRECT_PC & ~32'h0000_0003;
  assign misalign_hit_c = 1'b0;
`endif

  // Handshake terms: head valid, consume, response accept, request gating.
  assign valid_c   = RST_N && (state_q == ST_RUN) && (fb_cnt_q != '0);
  assign consume_c = valid_c && !STALL && !REDIRECT;
  assign rsp_c     = imem.IMEM_RVALID && (out_cnt_q != '0);
  assign write_c   = rsp_c && !out_disc_q[0] && !REDIRECT;
  assign load_c    = SUM_W'(out_cnt_q) + SUM_W'(fb_cnt_q) - SUM_W'(consume_c);
  assign req_c     = RST_N && started_q && (state_q == ST_RUN) && !REDIRECT
                     && (load_c < SUM_W'(2));
  assign grant_c   = req_c && imem.IMEM_GNT;

  assign imem.IMEM_REQ  = req_c;
  assign imem.IMEM_ADDR = pc_q;
  assign INST_VALID     = valid_c;
  assign INST           = valid_c ? fb_q[0].word : NOP_INST;
  assign INST_PC        = valid_c ? fb_q[0].pc : '0;
  assign MISALIGN       = misalign_q;

  // Run/halt next state: only a redirect can change it.
  always_comb begin
    state_d = state_q;
    if (REDIRECT) begin
      state_d = misalign_hit_c ? ST_HALT : ST_RUN;
    end
    misalign_d = (state_d == ST_HALT);
  end

  // State register for the run/halt FSM.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_RUN;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= misalign_d;
    end
  end

  // Next PC, outstanding-request tags and fetch buffer contents.
  always_comb begin
    started_d  = 1'b1;
    pc_d       = pc_q;
    fb_d       = fb_q;
    fb_cnt_d   = fb_cnt_q;
    out_pc_d   = out_pc_q;
    out_disc_d = out_disc_q;
    out_cnt_d  = out_cnt_q;

    if (rsp_c) begin
      out_pc_d[0]   = out_pc_q[1];
      out_disc_d[0] = out_disc_q[1];
      out_disc_d[1] = 1'b0;
      out_cnt_d     = out_cnt_q - CNT_W'(1);
    end
    if (grant_c) begin
      out_pc_d[out_cnt_d[0]]   = pc_q;
      out_disc_d[out_cnt_d[0]] = 1'b0;
      out_cnt_d                = out_cnt_d + CNT_W'(1);
      pc_d                     = pc_q + PC_STEP;
    end

    if (consume_c) begin
      fb_d[0]  = fb_q[1];
      fb_cnt_d = fb_cnt_q - CNT_W'(1);
    end
    if (write_c) begin
      fb_d[fb_cnt_d[0]] = '{pc: out_pc_q[0], word: imem.IMEM_RDATA};
      fb_cnt_d          = fb_cnt_d + CNT_W'(1);
    end

    // Redirect wins: flush buffer, retarget PC, orphan everything in flight.
    if (REDIRECT) begin
      fb_cnt_d   = '0;
      pc_d       = redirect_pc_c;
      out_disc_d = 2'b11;
    end
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      started_q  <= 1'b0;
      pc_q       <= RESET_PC;
      fb_q       <= '{default: '0};
      fb_cnt_q   <= '0;
      out_pc_q   <= '{default: '0};
      out_disc_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      started_q  <= started_d;
      pc_q       <= pc_d;
      fb_q       <= fb_d;
      fb_cnt_q   <= fb_cnt_d;
      out_pc_q   <= out_pc_d;
      out_disc_q <= out_disc_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_core_fetch.sv
// Bench for core_fetch: in-order memory model with random grant/latency and
// an architectural scoreboard (expected instruction PC stream).
module tb_core_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] SALT     = 32'hA5A5_0000;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        STALL = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic [31:0] INST, INST_PC;
  logic        INST_VALID, MISALIGN;

  core_fetch_if imem();

  core_fetch #(.RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .REDIRECT(REDIRECT),
    .REDIRECT_PC(REDIRECT_PC), .imem(imem), .INST(INST), .INST_PC(INST_PC),
    .INST_VALID(INST_VALID), .MISALIGN(MISALIGN)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int gnt_mode = 1;   // 0 random, 1 always, 2 never
  int gnt_pct  = 60;
  int lat_min  = 1;
  int lat_max  = 1;

  logic        d_rst_n = 1'b0, d_stall = 1'b0, d_redirect = 1'b0;
  logic [31:0] d_rpc = '0;

  logic [31:0] mem_addr[$];
  int          mem_due[$];

  logic [31:0] exp_pc = RESET_PC;
  int          live = 0;
  logic        req_pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic        after_redir = 1'b0;
  logic        halted = 1'b0;
  int          since_rst = 100;

  logic        s_req, s_valid, s_mis;
  logic [31:0] s_addr, s_inst, s_pc;
  logic [31:0] cons_log[$];
  int          n_cons = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, required %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs, sample/score at negedge, advance past posedge.
  task automatic cycle_step();
    logic rv, grant;
    int   lat;
    rv = (mem_due.size() > 0) && (mem_due[0] <= cyc);
    RST_N       = d_rst_n;
    STALL       = d_stall;
    REDIRECT    = d_redirect;
    REDIRECT_PC = d_rpc;
    imem.IMEM_GNT    = (gnt_mode == 1) ? 1'b1 :
                       (gnt_mode == 2) ? 1'b0 : ($urandom_range(0, 99) < gnt_pct);
    imem.IMEM_RVALID = rv;
    imem.IMEM_RDATA  = rv ? (mem_addr[0] ^ SALT) : $urandom;

    @(negedge CLK);
    s_req   = imem.IMEM_REQ;
    s_addr  = imem.IMEM_ADDR;
    s_valid = INST_VALID;
    s_inst  = INST;
    s_pc    = INST_PC;
    s_mis   = MISALIGN;

    if (!RST_N) begin
      check_eq("rst_req", 32'(s_req), 32'd0);
      check_eq("rst_valid", 32'(s_valid), 32'd0);
      check_eq("rst_inst", s_inst, NOP);
      exp_pc      = RESET_PC;
      live        = 0;
      req_pend    = 1'b0;
      after_redir = 1'b0;
      halted      = 1'b0;
      since_rst   = 0;
    end else begin
      if (since_rst == 0) begin
        check_eq("rel_c0_req", 32'(s_req), 32'd0);
        check_eq("rel_c0_valid", 32'(s_valid), 32'd0);
      end
      if (since_rst == 1 && !after_redir)
        check_eq("rel_c1_req", 32'(s_req), 32'(!REDIRECT));
      if (!s_valid) begin
        check_eq("idle_inst", s_inst, NOP);
        check_eq("idle_pc", s_pc, 32'd0);
      end
      check_eq("misalign", 32'(s_mis), 32'(halted));
      if (halted) begin
        check_eq("halt_req", 32'(s_req), 32'd0);
        check_eq("halt_valid", 32'(s_valid), 32'd0);
      end
      if (after_redir) begin
        check_eq("redir_next_valid", 32'(s_valid), 32'd0);
        check_eq("redir_next_req", 32'(s_req),
                 32'(!REDIRECT && !halted && (mem_addr.size() < 2)));
      end
      if (REDIRECT) check_eq("redir_req", 32'(s_req), 32'd0);
      if (req_pend && !REDIRECT) begin
        check_eq("req_hold", 32'(s_req), 32'd1);
        check_eq("addr_hold", s_addr, pend_addr);
      end
      if (s_valid && !STALL && !REDIRECT) begin
        check_eq("inst_pc", s_pc, exp_pc);
        check_eq("inst_word", s_inst, exp_pc ^ SALT);
        cons_log.push_back(s_pc);
        n_cons++;
        exp_pc = exp_pc + 32'd4;
        live--;
      end
      grant = s_req && imem.IMEM_GNT;
      if (grant) begin
        lat = $urandom_range(lat_min, lat_max);
        mem_addr.push_back(s_addr);
        mem_due.push_back(cyc + lat);
        live++;
        check_eq("in_flight_le2", 32'(live <= 2), 32'd1);
      end
      req_pend  = s_req && !imem.IMEM_GNT;
      pend_addr = s_addr;
      if (REDIRECT) begin
`ifdef CORE_FETCH_MISALIGN_EN
        halted = (REDIRECT_PC[1:0] != 2'b00);
        exp_pc = REDIRECT_PC;
`else
        halted = 1'b0;
        exp_pc = REDIRECT_PC & ~32'h3;
`endif
        live        = 0;
        req_pend    = 1'b0;
        after_redir = 1'b1;
      end else begin
        after_redir = 1'b0;
      end
      since_rst++;
    end

    @(posedge CLK);
    #1;
    if (rv) begin
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end
    cyc++;
  endtask

  task automatic run_until_cons(input int n, input int budget, input string tag);
    int start, k;
    start = n_cons;
    k = 0;
    while ((n_cons - start) < n && k < budget) begin
      cycle_step();
      k++;
    end
    check_eq({tag, "_progress"}, 32'((n_cons - start) >= n), 32'd1);
  endtask

  function automatic logic [31:0] cons_at(input int i);
    return (cons_log.size() > i) ? cons_log[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    logic [31:0] held_pc, held_inst;
    @(posedge CLK);
    #1;

    // Reset, then full-throughput stream from a 1-cycle memory.
    gnt_mode = 1; lat_min = 1; lat_max = 1;
    d_rst_n = 1'b0;
    repeat (3) cycle_step();
    d_rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      cycle_step();
      if (k == 1) begin
        check_eq("t1_c1_req", 32'(s_req), 32'd1);
        check_eq("t1_c1_addr", s_addr, RESET_PC);
      end
      if (k == 2) check_eq("t1_c2_valid", 32'(s_valid), 32'd0);
      if (k >= 3) begin
        check_eq("t1_valid", 32'(s_valid), 32'd1);
        check_eq("t1_pc", s_pc, RESET_PC + 32'(4 * (k - 3)));
        check_eq("t1_inst", s_inst, (RESET_PC + 32'(4 * (k - 3))) ^ SALT);
      end
    end

    // Decode stalls for 5 cycles with the stream running.
    d_stall = 1'b1;
    held_pc = '0;
    held_inst = '0;
    for (int i = 0; i < 5; i++) begin
      cycle_step();
      if (i == 0) begin
        held_pc   = s_pc;
        held_inst = s_inst;
      end else begin
        check_eq("t2_held_pc", s_pc, held_pc);
        check_eq("t2_held_inst", s_inst, held_inst);
      end
      check_eq("t2_valid", 32'(s_valid), 32'd1);
      if (i == 4) check_eq("t2_req_blocked", 32'(s_req), 32'd0);
    end
    d_stall = 1'b0;
    run_until_cons(4, 20, "t2");

    // Redirect to 0x100 with two requests in flight.
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 20 && mem_addr.size() != 2; k++) cycle_step();
    check_eq("t3_two_outstanding", 32'(mem_addr.size()), 32'd2);
    d_redirect = 1'b1; d_rpc = 32'h0000_0100;
    cycle_step();
    d_redirect = 1'b0;
    cons_log.delete();
    run_until_cons(1, 30, "t3");
    check_eq("t3_first_pc", cons_at(0), 32'h0000_0100);

    // PC wrap across the top of the address space.
    gnt_mode = 0; gnt_pct = 70; lat_min = 1; lat_max = 3;
    d_redirect = 1'b1; d_rpc = 32'hFFFF_FFF8;
    cycle_step();
    d_redirect = 1'b0;
    cons_log.delete();
    run_until_cons(3, 60, "t4");
    check_eq("t4_pc0", cons_at(0), 32'hFFFF_FFF8);
    check_eq("t4_pc1", cons_at(1), 32'hFFFF_FFFC);
    check_eq("t4_pc2", cons_at(2), 32'h0000_0000);

    // One-cycle reset with a request in flight; its response lands after.
    gnt_mode = 2;
    repeat (8) cycle_step();
    gnt_mode = 1; lat_min = 2; lat_max = 2;
    cycle_step();
    check_eq("t5_grant", 32'(s_req), 32'd1);
    gnt_mode = 2;
    d_rst_n = 1'b0;
    cycle_step();
    d_rst_n = 1'b1;
    gnt_mode = 1; lat_min = 1; lat_max = 1;
    cons_log.delete();
    run_until_cons(2, 20, "t5");
    check_eq("t5_first_pc", cons_at(0), RESET_PC);

    // Misaligned redirect target.
    d_redirect = 1'b1; d_rpc = 32'h0000_0102;
    cycle_step();
    d_redirect = 1'b0;
`ifdef CORE_FETCH_MISALIGN_EN
    repeat (5) cycle_step();
    check_eq("t6_misalign", 32'(s_mis), 32'd1);
    check_eq("t6_req", 32'(s_req), 32'd0);
    d_redirect = 1'b1; d_rpc = 32'h0000_0200;
    cycle_step();
    d_redirect = 1'b0;
    cons_log.delete();
    run_until_cons(1, 20, "t6");
    check_eq("t6_resume_pc", cons_at(0), 32'h0000_0200);
`else
    cons_log.delete();
    run_until_cons(1, 20, "t6");
    check_eq("t6_resume_pc", cons_at(0), 32'h0000_0100);
    check_eq("t6_misalign", 32'(s_mis), 32'd0);
`endif

    // Random traffic: stalls, grants, latencies, redirects, resets.
    gnt_mode = 0; gnt_pct = 60; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      d_stall    = ($urandom_range(0, 99) < 30);
      d_redirect = ($urandom_range(0, 99) < 3);
      d_rpc      = $urandom & ~32'h3;
      if ($urandom_range(0, 999) < 4) begin
        mem_addr.delete();
        mem_due.delete();
        d_rst_n    = 1'b0;
        d_redirect = 1'b0;
      end
      cycle_step();
      d_rst_n = 1'b1;
    end
    d_stall = 1'b0;
    d_redirect = 1'b0;
    run_until_cons(3, 60, "final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/core_fetch.md
CORE_FETCH -- requirements
Module: core_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port: CLK  input  1  clock; all state on rising edge.
REQ-003 SHALL have port: RST_N  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: STALL  input  1  decode stage cannot accept INST this cycle.
REQ-005 SHALL have port: REDIRECT  input  1  branch/jump taken; restart fetch.
REQ-006 SHALL have port: REDIRECT_PC  input  32  new fetch address, sampled when REDIRECT=1.
REQ-007 SHALL have port: IMEM_REQ  output  1  instruction memory read request.
REQ-008 SHALL have port: IMEM_ADDR  output  32  byte address of the request.
REQ-009 SHALL have port: IMEM_GNT  input  1  request accepted this cycle.
REQ-010 SHALL have port: IMEM_RVALID  input  1  read data valid; responses in order, at least 1 cycle after grant.
REQ-011 SHALL have port: IMEM_RDATA  input  32  instruction word.
REQ-012 SHALL have port: INST  output  32  instruction word to the decoder.
REQ-013 SHALL have port: INST_PC  output  32  address of INST.
REQ-014 SHALL have port: INST_VALID  output  1  INST/INST_PC hold a real instruction.
REQ-015 SHALL have port: MISALIGN  output  1  misaligned redirect detected (see Configuration).

Function
REQ-016 SHALL keep a fetch PC; each granted request (IMEM_REQ & IMEM_GNT) advances PC by 4, 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-017 SHALL hold a 2-entry in-order buffer of {PC, word}; INST/INST_PC/INST_VALID are driven from the head entry.
REQ-018 SHALL treat an entry as consumed in a cycle with INST_VALID=1 and STALL=0; the next entry is presented the following cycle.
REQ-019 SHALL drive INST=32'h0000_0013 (addi x0,x0,0) and INST_PC=0 whenever INST_VALID=0.
REQ-020 SHALL assert IMEM_REQ only when outstanding + buffer occupancy - (consume this cycle) < 2; IMEM_ADDR=PC; IMEM_REQ/IMEM_ADDR held stable until granted.
REQ-021 SHALL count outstanding requests (0..2), +1 on grant, -1 on IMEM_RVALID; simultaneous grant and RVALID leave the count unchanged.
REQ-022 SHALL write IMEM_RDATA into the buffer on IMEM_RVALID, tagged with the PC of the matching request, unless that response is marked discard.
REQ-023 SHALL support full throughput: with a 1-cycle memory, STALL=0 and GNT=1, one INST_VALID per cycle from the third cycle after reset release.
REQ-024 SHALL on REDIRECT=1: empty the buffer, set PC=REDIRECT_PC, mark all outstanding responses discard, deassert IMEM_REQ that cycle; INST_VALID=0 next cycle.
REQ-025 SHALL give REDIRECT priority over STALL, consume, RVALID write and grant in the same cycle; a pending ungranted request is withdrawn.
REQ-026 SHALL drop discard-marked responses while still decrementing outstanding; first post-redirect request issues the cycle after REDIRECT.
REQ-027 SHALL ignore IMEM_RVALID when outstanding=0.
REQ-028 SHALL implement states RUN and HALT; RUN -> HALT only per REQ-033; HALT exits only via reset or REDIRECT with aligned REDIRECT_PC.

Reset
REQ-029 SHALL, while RST_N=0 at a clock edge, set PC=RESET_PC, buffer empty, outstanding=0, discard marks clear, state RUN, MISALIGN=0.
REQ-030 SHALL hold IMEM_REQ=0, INST_VALID=0, INST=32'h0000_0013 during reset and the first cycle after release; first IMEM_REQ the second cycle after release.
REQ-031 SHALL discard responses to requests granted before a mid-operation reset (covered by REQ-027).

Configuration
REQ-032 SHALL use macro CORE_FETCH_MISALIGN_EN.
REQ-033 SHALL, with CORE_FETCH_MISALIGN_EN defined: REDIRECT with REDIRECT_PC[1:0]!=0 enters HALT, MISALIGN=1 from next cycle, no requests, INST_VALID=0 until exit.
REQ-034 SHALL, without CORE_FETCH_MISALIGN_EN: REDIRECT_PC[1:0] forced to 0, HALT unreachable, MISALIGN tied 0.

Verification
REQ-035 SHALL cover: reset release, RESET_PC=0, 1-cycle memory returning addr^32'hA5A5_0000 -> INST_PC 0,4,8 on consecutive cycles from cycle 3, INST matching.
REQ-036 SHALL cover: STALL=1 for 5 cycles with stream running -> INST held, at most 2 granted-but-unconsumed, no lost or duplicated PC.
REQ-037 SHALL cover: REDIRECT to 32'h0000_0100 with 2 outstanding -> both stale responses dropped, next INST_VALID has INST_PC=32'h100.
REQ-038 SHALL cover: PC=32'hFFFF_FFF8, run 3 fetches -> INST_PC FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 SHALL cover: RST_N low 1 cycle with 1 outstanding, RVALID arriving after -> ignored, first INST_PC=RESET_PC.
REQ-040 SHALL cover: REDIRECT_PC=32'h0000_0102 -> with macro MISALIGN=1, IMEM_REQ=0 until aligned redirect; without macro fetch resumes at 32'h100.
